xor_dut_tester: RTL

//   Hardware-side driver/checker for the TESTPORT end of dut_if. Resets the XOR dut, drives

---
 rtl/xor_dut_tester.sv | 138 +++++++++++++
 1 files changed

// File: rtl/xor_dut_tester.sv
// Built-in tester for an XOR dut: resets it, drives LFSR operand pairs and
// checks result against in1^in2 after a fixed latency, reporting error status.
module xor_dut_tester #(
    parameter int          WIDTH      = 32,
    parameter int          LAT        = 1,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] SEED1      = 32'hACE1_2468,
    parameter logic [31:0] SEED2      = 32'h1357_BDF0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      num_vectors,
    output logic             dut_reset,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             rst_err,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    typedef enum logic [2:0] {IDLE, RST_DUT, DRIVE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             v;
        logic [15:0]      idx;
        logic [WIDTH-1:0] x;
    } exp_t;

    // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LAT_LAST = 16'(LAT - 1);
    localparam logic [15:0] NONE     = 16'hFFFF;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    state_t      state, state_nxt;
    logic [31:0] lfsr1, lfsr2;
    logic [15:0] cnt, nv;
    exp_t        pipe [LAT];
    logic        accept, rst_end, last_vec, rst_chk, mismatch;

    assign busy = (state == RST_DUT) || (state == DRIVE) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0) && !rst_err;

    assign last_vec = (cnt == nv - 16'd1);
    // The first reset edge still sees the dut's pre-reset output
    assign rst_chk  = (state == RST_DUT) && (cnt != 16'd0) && (result !== '0);
    assign mismatch = pipe[LAT-1].v && (result !== pipe[LAT-1].x);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rst_end   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RST_DUT;
                end
            end
            RST_DUT: begin
                if (cnt == RST_LAST) begin
                    rst_end   = 1'b1;
                    state_nxt = (nv == 16'd0) ? DRAIN : DRIVE;
                end
            end
            DRIVE: begin
                if (last_vec) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cnt == LAT_LAST) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dut_reset     <= 1'b1;
            in1           <= '0;
            in2           <= '0;
            rst_err       <= 1'b0;
            err_count     <= 16'd0;
            first_err_idx <= NONE;
            lfsr1         <= SEED1;
            lfsr2         <= SEED2;
            cnt           <= 16'd0;
            nv            <= 16'd0;
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            cnt <= (state_nxt != state || !busy) ? 16'd0 : cnt + 16'd1;
            for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= {state == DRIVE, cnt, in1 ^ in2};
            if (accept) begin
                dut_reset     <= 1'b1;
                in1           <= '0;
                in2           <= '0;
                rst_err       <= 1'b0;
                err_count     <= 16'd0;
                first_err_idx <= NONE;
                lfsr1         <= SEED1;
                lfsr2         <= SEED2;
                nv            <= num_vectors;
            end else begin
                if (rst_chk) rst_err <= 1'b1;
                if (mismatch) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (first_err_idx == NONE) first_err_idx <= pipe[LAT-1].idx;
                end
                if ((rst_end && nv != 16'd0) || (state == DRIVE && !last_vec)) begin
                    in1   <= lfsr1[WIDTH-1:0];
                    in2   <= lfsr2[WIDTH-1:0];
                    lfsr1 <= lfsr_step(lfsr1);
                    lfsr2 <= lfsr_step(lfsr2);
                end else if (rst_end || state == DRIVE) begin
                    in1 <= '0;
                    in2 <= '0;
                end
                if (rst_end) dut_reset <= 1'b0;
            end
        end
    end

endmodule
